// File: rtl/count_seq_pkg.sv
// count_seq_pkg
//   Shared types and defaults for the counter sequencer.
//   - seq_state_t : sequencer FSM states
//   - WIDTH_DEF   : default counter / command field width
//   - HOLD_DEF    : default idle gap between passes, in cycles
package count_seq_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int HOLD_DEF  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COUNT,
        S_HOLD,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/count_seq_ctrl_hold_timer.sv
// hold_timer
//   Down-counter that times the idle gap between passes.
//   Ports:
//     clk    in  system clock
//     reset  in  synchronous active-low reset
//     load   in  pulse on the cycle that transitions into HOLD
//     run    in  high while the FSM sits in HOLD
//     expire out high on the last HOLD cycle
module hold_timer #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic run,
    output logic expire
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);

    logic [CW-1:0] remain;

    // Loaded with HOLD_CYCLES-1 so the first HOLD cycle already counts;
    // expire on zero gives exactly HOLD_CYCLES cycles in HOLD.
    always_ff @(posedge clk) begin
        if (!reset)
            remain <= '0;
        else if (load)
            remain <= CW'(HOLD_CYCLES - 1);
        else if (run && remain != '0)
            remain <= remain - 1'b1;
    end

    assign expire = (remain == '0);

endmodule

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl
//   Sequences an external up-counter: clear, count 0..target, idle gap,
//   repeated for a given number of passes.
//   Ports:
//     clk, reset         clock, synchronous active-low reset
//     start / ready      command handshake (accept on start && ready)
//     target, loops      terminal count and pass count, latched on accept
//     pause              freezes counting in COUNT
//     abort              cancels an active command, no done pulse
//     cnt_q              counter value fed back
//     cnt_en, cnt_clr    counter enable / synchronous clear
//     busy, done         command in progress / completion pulse
//     loop_idx           current pass, 0-based
module count_seq_ctrl
    import count_seq_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int HOLD_CYCLES = HOLD_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] loops,
    input  logic             pause,
    input  logic             abort,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] loop_idx
);

    seq_state_t       state, state_nxt;
    logic [WIDTH-1:0] tgt_q, tgt_nxt;
    logic [WIDTH-1:0] loops_q, loops_nxt;
    logic [WIDTH-1:0] idx_nxt;
    logic             hold_load, hold_expire;
    logic             at_target, last_pass;

    assign at_target = (cnt_q == tgt_q);
    // loops_q >= 1 whenever this is used (loops==0 skips straight to DONE).
    assign last_pass = (loop_idx == WIDTH'(loops_q - 1'b1));

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold (
        .clk   (clk),
        .reset (reset),
        .load  (hold_load),
        .run   (state == S_HOLD),
        .expire(hold_expire)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            tgt_q    <= '0;
            loops_q  <= '0;
            loop_idx <= '0;
        end else begin
            state    <= state_nxt;
            tgt_q    <= tgt_nxt;
            loops_q  <= loops_nxt;
            loop_idx <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tgt_nxt   = tgt_q;
        loops_nxt = loops_q;
        idx_nxt   = loop_idx;
        ready     = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        cnt_en    = 1'b0;
        cnt_clr   = 1'b0;
        hold_load = 1'b0;

        case (state)
            S_IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (start) begin
                    tgt_nxt   = target;
                    loops_nxt = loops;
                    idx_nxt   = '0;
                    state_nxt = (loops == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_clr   = 1'b1;
                state_nxt = S_COUNT;
            end
            S_COUNT: begin
                // pause only gates the enable; the exit check still runs.
                cnt_en = !pause && !at_target;
                if (at_target) begin
                    if (last_pass) begin
                        state_nxt = S_DONE;
                    end else begin
                        idx_nxt   = loop_idx + 1'b1;
                        hold_load = 1'b1;
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (hold_expire)
                    state_nxt = S_CLEAR;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // abort overrides everything outside IDLE, including the done pulse.
        if (abort && state != S_IDLE) begin
            state_nxt = S_IDLE;
            idx_nxt   = '0;
            cnt_en    = 1'b0;
            done      = 1'b0;
            hold_load = 1'b0;
        end
    end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl
//   Self-checking bench for count_seq_ctrl with a behavioural counter model.
//   Expected done-pulse cycles are queued when a command is issued and
//   matched against the observed done pulses.
module tb_count_seq_ctrl;

    localparam int W  = 4;
    localparam int HC = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] target = '0;
    logic [W-1:0] loops = '0;
    logic [W-1:0] cnt_q;
    logic         ready, cnt_en, cnt_clr, busy, done;
    logic [W-1:0] loop_idx;

    int cyc = 0;
    int c0 = 0;
    int pass_cnt = 0;
    int total_cnt = 0;
    int exp_q[$];
    int done_log[$];

    count_seq_ctrl #(.WIDTH(W), .HOLD_CYCLES(HC)) dut (
        .clk(clk), .reset(reset), .start(start), .ready(ready),
        .target(target), .loops(loops), .pause(pause), .abort(abort),
        .cnt_q(cnt_q), .cnt_en(cnt_en), .cnt_clr(cnt_clr), .busy(busy),
        .done(done), .loop_idx(loop_idx)
    );

    always #5 clk = ~clk;

    // counter model: clear has priority over enable
    always @(posedge clk) begin
        if (!reset || cnt_clr) cnt_q <= '0;
        else if (cnt_en)       cnt_q <= cnt_q + 1'b1;
    end

    // cyc = index of the cycle that ends at this edge
    always @(posedge clk) begin
        if (done) done_log.push_back(cyc);
        cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic goto(input int k);
        for (int i = 0; i < 200 && cyc < c0 + k; i++) tick();
        total_cnt++;
        if (cyc !== c0 + k) $display("FAIL goto: got cycle %0d want %0d", cyc, c0 + k);
        else pass_cnt++;
    endtask

    // accept happens at the end of cycle c0; returns in cycle c0+1
    task automatic issue(input logic [W-1:0] t, input logic [W-1:0] l);
        total_cnt++;
        if (ready !== 1'b1) $display("FAIL issue_ready: got %0b want 1", ready);
        else pass_cnt++;
        start = 1'b1; target = t; loops = l; c0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic check_sb(input string name);
        int e, a;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (done_log.size() == 0) begin
                $display("FAIL %s_done: got no pulse want cycle %0d", name, e);
            end else begin
                a = done_log.pop_front();
                if (a !== e) $display("FAIL %s_done: got cycle %0d want %0d", name, a, e);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (done_log.size() != 0) begin
            $display("FAIL %s_extra_done: got %0d extra pulses want 0", name, done_log.size());
            done_log.delete();
        end else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b0; tick(); tick();
        total_cnt++; if (ready !== 1'b1)   $display("FAIL rst_ready: got %0b want 1", ready);     else pass_cnt++;
        total_cnt++; if (busy !== 1'b0)    $display("FAIL rst_busy: got %0b want 0", busy);       else pass_cnt++;
        total_cnt++; if (cnt_en !== 1'b0)  $display("FAIL rst_en: got %0b want 0", cnt_en);       else pass_cnt++;
        total_cnt++; if (cnt_clr !== 1'b0) $display("FAIL rst_clr: got %0b want 0", cnt_clr);     else pass_cnt++;
        total_cnt++; if (done !== 1'b0)    $display("FAIL rst_done: got %0b want 0", done);       else pass_cnt++;
        total_cnt++; if (loop_idx !== '0)  $display("FAIL rst_idx: got %0d want 0", loop_idx);    else pass_cnt++;
        reset = 1'b1; tick();
        total_cnt++; if (ready !== 1'b1)   $display("FAIL rst_ready2: got %0b want 1", ready);    else pass_cnt++;
        check_sb("reset");
    endtask

    task automatic test_single();
        issue(4'd5, 4'd1);
        total_cnt++; if (cnt_clr !== 1'b1) $display("FAIL single_clr: got %0b want 1", cnt_clr); else pass_cnt++;
        exp_q.push_back(c0 + 8);
        for (int k = 2; k <= 6; k++) begin
            goto(k);
            total_cnt++; if (cnt_en !== 1'b1) $display("FAIL single_en_t%0d: got %0b want 1", k, cnt_en); else pass_cnt++;
        end
        goto(7);
        total_cnt++; if (cnt_q !== 4'd5)  $display("FAIL single_q: got %0d want 5", cnt_q);   else pass_cnt++;
        total_cnt++; if (cnt_en !== 1'b0) $display("FAIL single_en_t7: got %0b want 0", cnt_en); else pass_cnt++;
        goto(8);
        total_cnt++; if (done !== 1'b1)   $display("FAIL single_done_t8: got %0b want 1", done); else pass_cnt++;
        goto(9);
        total_cnt++; if (ready !== 1'b1)  $display("FAIL single_ready_t9: got %0b want 1", ready); else pass_cnt++;
        check_sb("single");
    endtask

    task automatic test_two_loops();
        logic exp_en, exp_clr;
        issue(4'd3, 4'd2);
        exp_q.push_back(c0 + 13);
        for (int k = 1; k <= 13; k++) begin
            goto(k);
            exp_en  = (k >= 2 && k <= 4) || (k >= 9 && k <= 11);
            exp_clr = (k == 1) || (k == 8);
            total_cnt++; if (cnt_en !== exp_en)   $display("FAIL loop2_en_t%0d: got %0b want %0b", k, cnt_en, exp_en);    else pass_cnt++;
            total_cnt++; if (cnt_clr !== exp_clr) $display("FAIL loop2_clr_t%0d: got %0b want %0b", k, cnt_clr, exp_clr); else pass_cnt++;
            if (k == 5) begin
                total_cnt++; if (loop_idx !== 4'd0) $display("FAIL loop2_idx0: got %0d want 0", loop_idx); else pass_cnt++;
            end
            if (k == 6) begin
                total_cnt++; if (loop_idx !== 4'd1) $display("FAIL loop2_idx1: got %0d want 1", loop_idx); else pass_cnt++;
            end
            if (k == 12) begin
                total_cnt++; if (cnt_q !== 4'd3) $display("FAIL loop2_q: got %0d want 3", cnt_q); else pass_cnt++;
            end
        end
        tick(); tick();
        check_sb("loop2");
    endtask

    task automatic test_pause_busy_start();
        issue(4'd9, 4'd1);
        exp_q.push_back(c0 + 16);
        for (int k = 2; k <= 16; k++) begin
            goto(k);
            pause = (k >= 6 && k <= 9);
            start = (k == 3);
            if (k == 3) begin
                target = 4'd2; loops = 4'd0;
                total_cnt++; if (ready !== 1'b0) $display("FAIL pause_ready_busy: got %0b want 0", ready); else pass_cnt++;
            end
            if (k >= 6 && k <= 10) begin
                total_cnt++; if (cnt_q !== 4'd4) $display("FAIL pause_q_t%0d: got %0d want 4", k, cnt_q); else pass_cnt++;
            end
            if (k >= 7 && k <= 9) begin
                total_cnt++; if (cnt_en !== 1'b0) $display("FAIL pause_en_t%0d: got %0b want 0", k, cnt_en); else pass_cnt++;
            end
            if (k == 12) begin
                total_cnt++; if (done !== 1'b0) $display("FAIL pause_early_done: got %0b want 0", done); else pass_cnt++;
            end
            if (k == 15) begin
                total_cnt++; if (cnt_q !== 4'd9) $display("FAIL pause_q_end: got %0d want 9", cnt_q); else pass_cnt++;
            end
        end
        total_cnt++; if (done !== 1'b1) $display("FAIL pause_done_t16: got %0b want 1", done); else pass_cnt++;
        goto(17);
        total_cnt++; if (ready !== 1'b1) $display("FAIL pause_ready: got %0b want 1", ready); else pass_cnt++;
        check_sb("pause");
    endtask

    task automatic test_abort();
        issue(4'd15, 4'd1);
        goto(9);
        total_cnt++; if (cnt_q !== 4'd7) $display("FAIL abort_q: got %0d want 7", cnt_q); else pass_cnt++;
        abort = 1'b1;
        #1;
        total_cnt++; if (cnt_en !== 1'b0) $display("FAIL abort_en_forced: got %0b want 0", cnt_en); else pass_cnt++;
        tick();
        abort = 1'b0;
        #1;
        total_cnt++; if (ready !== 1'b1)    $display("FAIL abort_ready: got %0b want 1", ready);   else pass_cnt++;
        total_cnt++; if (busy !== 1'b0)     $display("FAIL abort_busy: got %0b want 0", busy);     else pass_cnt++;
        total_cnt++; if (cnt_en !== 1'b0)   $display("FAIL abort_en: got %0b want 0", cnt_en);     else pass_cnt++;
        total_cnt++; if (loop_idx !== 4'd0) $display("FAIL abort_idx: got %0d want 0", loop_idx);  else pass_cnt++;
        goto(20);
        total_cnt++; if (cnt_q !== 4'd7)    $display("FAIL abort_q_held: got %0d want 7", cnt_q);  else pass_cnt++;
        check_sb("abort");
    endtask

    task automatic test_edges();
        // loops == 0: straight to DONE
        issue(4'd5, 4'd0);
        exp_q.push_back(c0 + 1);
        total_cnt++; if (done !== 1'b1)   $display("FAIL l0_done: got %0b want 1", done);     else pass_cnt++;
        total_cnt++; if (cnt_en !== 1'b0) $display("FAIL l0_en: got %0b want 0", cnt_en);    else pass_cnt++;
        goto(2);
        total_cnt++; if (ready !== 1'b1)  $display("FAIL l0_ready: got %0b want 1", ready);  else pass_cnt++;
        check_sb("loops0");
        // target == 0: one COUNT cycle, no increments
        issue(4'd0, 4'd1);
        exp_q.push_back(c0 + 3);
        goto(2);
        total_cnt++; if (cnt_en !== 1'b0) $display("FAIL t0_en: got %0b want 0", cnt_en);    else pass_cnt++;
        goto(3);
        total_cnt++; if (done !== 1'b1)   $display("FAIL t0_done: got %0b want 1", done);    else pass_cnt++;
        tick();
        check_sb("target0");
    endtask

    task automatic test_reset_in_hold();
        issue(4'd3, 4'd2);
        goto(6);
        total_cnt++; if (busy !== 1'b1)     $display("FAIL rh_busy: got %0b want 1", busy);      else pass_cnt++;
        total_cnt++; if (loop_idx !== 4'd1) $display("FAIL rh_idx: got %0d want 1", loop_idx);   else pass_cnt++;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        total_cnt++; if (ready !== 1'b1)    $display("FAIL rh_ready: got %0b want 1", ready);    else pass_cnt++;
        total_cnt++; if (busy !== 1'b0)     $display("FAIL rh_busy0: got %0b want 0", busy);     else pass_cnt++;
        total_cnt++; if (cnt_en !== 1'b0)   $display("FAIL rh_en: got %0b want 0", cnt_en);      else pass_cnt++;
        total_cnt++; if (cnt_clr !== 1'b0)  $display("FAIL rh_clr: got %0b want 0", cnt_clr);    else pass_cnt++;
        total_cnt++; if (loop_idx !== 4'd0) $display("FAIL rh_idx0: got %0d want 0", loop_idx);  else pass_cnt++;
        goto(20);
        total_cnt++; if (busy !== 1'b0)     $display("FAIL rh_stays_idle: got %0b want 0", busy); else pass_cnt++;
        check_sb("reset_hold");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_two_loops();
        test_pause_busy_start();
        test_abort();
        test_edges();
        test_reset_in_hold();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
